// File: rtl/sobel_pkg.sv
// Shared mode encodings and magnitude-width derivation for the Sobel/skin fusion core.
package sobel_pkg;

    typedef enum logic [1:0] {
        MODE_EDGE = 2'd0,
        MODE_MASK = 2'd1,
        MODE_AND  = 2'd2,
        MODE_OR   = 2'd3
    } mode_e;

    localparam int MAG_EXTRA_BITS = 3;

    function automatic int mag_width(input int dw);
        return dw + MAG_EXTRA_BITS;
    endfunction

endpackage

// File: rtl/line_buf2.sv
// Two cascaded column-addressed line stores: tap1 = previous line, tap2 = line before that.
// Combinational read, write on we_i; contents are never reset.
module line_buf2 #(
    parameter int DW    = 10,
    parameter int IMG_W = 640,
    parameter int AW    = (IMG_W > 1) ? $clog2(IMG_W) : 1
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] din_i,
    output logic [DW-1:0] tap1_o,
    output logic [DW-1:0] tap2_o
);

    logic [DW-1:0] line1_q [IMG_W];
    logic [DW-1:0] line2_q [IMG_W];

    assign tap1_o = line1_q[addr_i];
    assign tap2_o = line2_q[addr_i];

    always_ff @(posedge clk) begin
        if (we_i) begin
            line1_q[addr_i] <= din_i;
            line2_q[addr_i] <= line1_q[addr_i];
        end
    end

endmodule

// File: rtl/sobel_skin_core.sv
// Sobel |Gx|+|Gy| edge detector fused with a skin mask; fixed 3-clock latency, one output per input beat.
// No backpressure: every per_clken beat is accepted and emitted three clocks later.
module sobel_skin_core
    import sobel_pkg::*;
#(
    parameter int DW    = 10,
    parameter int IMG_W = 640,
    parameter int MW    = mag_width(DW)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          per_frame_vsync,
    input  logic          per_frame_href,
    input  logic          per_clken,
    input  logic [DW-1:0] per_img_Y,
    input  logic          per_mask,
    input  logic [1:0]    mode,
    input  logic [MW-1:0] threshold,
    output logic          post_frame_vsync,
    output logic          post_frame_href,
    output logic          post_clken,
    output logic [MW-1:0] post_mag,
    output logic          post_img_bit
);

    localparam int XW = $clog2(IMG_W + 1);
    localparam int AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int YW = 16;

    logic          vs_q, href_q;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    mode_e         mode_q, mode_d;

    logic accept, in_range, we, vs_rise, href_fall, interior;

    assign accept    = per_clken & per_frame_href;
    assign in_range  = (x_q < XW'(IMG_W));
    assign we        = accept & in_range;
    assign vs_rise   = per_frame_vsync & ~vs_q;
    assign href_fall = href_q & ~per_frame_href;
    assign interior  = we && (x_q >= XW'(2)) && (y_q >= YW'(2));

    always_comb begin
        x_d    = x_q;
        y_d    = y_q;
        mode_d = mode_q;
        if (href_fall) begin
            x_d = '0;
        end else if (we) begin
            x_d = x_q + 1'b1;
        end
        if (vs_rise) begin
            y_d    = '0;
            mode_d = mode_e'(mode);
        end else if (href_fall && (y_q != '1)) begin
            y_d = y_q + 1'b1;
        end
    end

    logic [DW-1:0] tap1, tap2;

    line_buf2 #(.DW(DW), .IMG_W(IMG_W), .AW(AW)) u_line_buf2 (
        .clk    (clk),
        .we_i   (we),
        .addr_i (x_q[AW-1:0]),
        .din_i  (per_img_Y),
        .tap1_o (tap1),
        .tap2_o (tap2)
    );

    // Column index [0] is the oldest line (y-2), [2] the pixel arriving now.
    logic [2:0][DW-1:0] cur_col, col1_q, col2_q;
    assign cur_col = {per_img_Y, tap1, tap2};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_q   <= 1'b0;
            href_q <= 1'b0;
            x_q    <= '0;
            y_q    <= '0;
            mode_q <= MODE_EDGE;
            col1_q <= '0;
            col2_q <= '0;
        end else begin
            vs_q   <= per_frame_vsync;
            href_q <= per_frame_href;
            x_q    <= x_d;
            y_q    <= y_d;
            mode_q <= mode_d;
            if (we) begin
                col2_q <= col1_q;
                col1_q <= cur_col;
            end
        end
    end

    logic [2:0][2:0][DW-1:0] win_d, win_q;

    always_comb begin
        win_d = '0;
        for (int r = 0; r < 3; r++) begin
            win_d[r][0] = col2_q[r];
            win_d[r][1] = col1_q[r];
            win_d[r][2] = cur_col[r];
        end
    end

    function automatic logic signed [MW-1:0] ext(input logic [DW-1:0] p);
        return $signed({{(MW-DW){1'b0}}, p});
    endfunction

    logic signed [MW-1:0] gx_d, gy_d, gx_q, gy_q;

    always_comb begin
        gx_d = ext(win_q[0][2]) + (ext(win_q[1][2]) <<< 1) + ext(win_q[2][2])
             - ext(win_q[0][0]) - (ext(win_q[1][0]) <<< 1) - ext(win_q[2][0]);
        gy_d = ext(win_q[2][0]) + (ext(win_q[2][1]) <<< 1) + ext(win_q[2][2])
             - ext(win_q[0][0]) - (ext(win_q[0][1]) <<< 1) - ext(win_q[0][2]);
    end

    logic          vld1_q, int1_q, msk1_q, vs1_q, hr1_q;
    logic          vld2_q, int2_q, msk2_q, vs2_q, hr2_q;
    logic [MW-1:0] abs_x, abs_y, mag_d;
    logic          edge_hit, bit_d;

    always_comb begin
        abs_x    = gx_q[MW-1] ? MW'(-gx_q) : MW'(gx_q);
        abs_y    = gy_q[MW-1] ? MW'(-gy_q) : MW'(gy_q);
        mag_d    = (vld2_q && int2_q) ? (abs_x + abs_y) : '0;
        edge_hit = (mag_d > threshold);
        case (mode_q)
            MODE_EDGE: bit_d = edge_hit;
            MODE_MASK: bit_d = msk2_q;
            MODE_AND:  bit_d = edge_hit & msk2_q;
            MODE_OR:   bit_d = edge_hit | msk2_q;
            default:   bit_d = 1'b0;
        endcase
        if (!vld2_q) begin
            bit_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_q            <= '0;
            vld1_q           <= 1'b0;
            int1_q           <= 1'b0;
            msk1_q           <= 1'b0;
            vs1_q            <= 1'b0;
            hr1_q            <= 1'b0;
            gx_q             <= '0;
            gy_q             <= '0;
            vld2_q           <= 1'b0;
            int2_q           <= 1'b0;
            msk2_q           <= 1'b0;
            vs2_q            <= 1'b0;
            hr2_q            <= 1'b0;
            post_frame_vsync <= 1'b0;
            post_frame_href  <= 1'b0;
            post_clken       <= 1'b0;
            post_mag         <= '0;
            post_img_bit     <= 1'b0;
        end else begin
            win_q            <= win_d;
            vld1_q           <= per_clken;
            int1_q           <= interior;
            msk1_q           <= per_mask;
            vs1_q            <= per_frame_vsync;
            hr1_q            <= per_frame_href;
            gx_q             <= gx_d;
            gy_q             <= gy_d;
            vld2_q           <= vld1_q;
            int2_q           <= int1_q;
            msk2_q           <= msk1_q;
            vs2_q            <= vs1_q;
            hr2_q            <= hr1_q;
            post_frame_vsync <= vs2_q;
            post_frame_href  <= hr2_q;
            post_clken       <= vld2_q;
            post_mag         <= mag_d;
            post_img_bit     <= bit_d;
        end
    end

endmodule
